ext_mem_bridge: RTL

EXT_MEM_BRIDGE -- requirements
Module: ext_mem_bridge

---
 rtl/ext_mem_bridge.sv | 137 +++++++++++++
 1 files changed

// File: rtl/ext_mem_bridge.sv
// CPU-facing bridge to an internal word memory with programmable wait states and a
// 4-phase Ready handshake. Every output is a register; out-of-range requests are rejected.
module ext_mem_bridge #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        MemIO,
  input  logic [31:0]       ExternalAddressBus,
  input  logic [DATA_W-1:0] ExternalDataIn,
  output logic [DATA_W-1:0] ExternalDataOut,
  output logic              ExternalDataOE,
  output logic              ExternalExchangeReady,
  output logic              BusError,
  output logic              Busy
);

  localparam logic [3:0] WaitInit = 4'(WAIT_STATES);

  typedef enum logic [2:0] {StIdle, StWait, StAccess, StDone, StErr} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                oe_q, oe_d;
  logic                rdy_q, rdy_d;
  logic                berr_q, berr_d;
  logic                busy_q, busy_d;
  logic                out_of_range;

  logic [DATA_W-1:0]   mem [2**ADDR_W];

  assign out_of_range = |ExternalAddressBus[31:ADDR_W];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    oe_d    = oe_q;
    rdy_d   = rdy_q;
    berr_d  = berr_q;
    unique case (state_q)
      StIdle: begin
        if (MemIO == 2'b11 || (MemIO != 2'b00 && out_of_range)) begin
          state_d = StErr;
          rdy_d   = 1'b1;
          berr_d  = 1'b1;
        end else if (MemIO != 2'b00) begin
          wr_d    = (MemIO == 2'b10);
          addr_d  = ExternalAddressBus[ADDR_W-1:0];
          wdata_d = ExternalDataIn;
          if (WAIT_STATES == 0) begin
            state_d = StAccess;
            cnt_d   = '0;
          end else begin
            state_d = StWait;
            cnt_d   = WaitInit;
          end
        end
      end
      StWait: begin
        // Dropping the request before the access commits abandons it silently.
        if (MemIO == 2'b00) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = StAccess;
        end
      end
      StAccess: begin
        state_d = StDone;
        rdy_d   = 1'b1;
        if (!wr_q) begin
          oe_d   = 1'b1;
          dout_d = mem[addr_q];
        end
      end
      StDone, StErr: begin
        if (MemIO == 2'b00) begin
          state_d = StIdle;
          rdy_d   = 1'b0;
          oe_d    = 1'b0;
          berr_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      dout_q  <= '0;
      oe_q    <= 1'b0;
      rdy_q   <= 1'b0;
      berr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      oe_q    <= oe_d;
      rdy_q   <= rdy_d;
      berr_q  <= berr_d;
      busy_q  <= busy_d;
    end
  end

  // Memory has no reset; a reset forces IDLE so a pending write never reaches it.
  always_ff @(posedge clk) begin
    if (state_q == StAccess && wr_q) mem[addr_q] <= wdata_q;
  end

  assign ExternalDataOut       = dout_q;
  assign ExternalDataOE        = oe_q;
  assign ExternalExchangeReady = rdy_q;
  assign BusError              = berr_q;
  assign Busy                  = busy_q;

endmodule
